// File: rtl/result_pipe_if.sv
// Bundle of EX-side producer inputs, forwarding lookups and write-back outputs
// for result_pipe. The pipeline core takes the slave modport.
interface result_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int NRD    = 2
);
  logic                   in_wreg;
  logic [ADDR_W-1:0]      in_wd;
  logic [DATA_W-1:0]      in_wdata;
  logic                   in_late;
  logic [DATA_W-1:0]      late_wdata;
  logic [DEPTH-1:0]       stall;
  logic                   flush;
  logic [NRD*ADDR_W-1:0]  rd_addr;
  logic [NRD-1:0]         rd_hit;
  logic [NRD*DATA_W-1:0]  rd_data;
  logic [NRD-1:0]         rd_stall;
  logic                   wb_wreg;
  logic [ADDR_W-1:0]      wb_wd;
  logic [DATA_W-1:0]      wb_wdata;
  logic                   busy;

  modport master (
    output in_wreg, in_wd, in_wdata, in_late, late_wdata, stall, flush, rd_addr,
    input  rd_hit, rd_data, rd_stall, wb_wreg, wb_wd, wb_wdata, busy
  );

  modport slave (
    input  in_wreg, in_wd, in_wdata, in_late, late_wdata, stall, flush, rd_addr,
    output rd_hit, rd_data, rd_stall, wb_wreg, wb_wd, wb_wdata, busy
  );
endinterface

// File: rtl/result_pipe.sv
// Result pipeline from EX to write-back: DEPTH stages with per-stage stall and
// bubble insertion, global flush, late (load) data capture and forwarding ports.
module result_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int NRD      = 2,
  parameter int LATE_STG = 2
) (
  input logic          clk,
  input logic          rst,
  result_pipe_if.slave bus
);

  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  rdy;
  logic [ADDR_W-1:0] wd    [DEPTH];
  logic [DATA_W-1:0] wdata [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld[i]   <= 1'b0;
        rdy[i]   <= 1'b1;
        wd[i]    <= '0;
        wdata[i] <= '0;
      end
    end else begin
      if (!bus.stall[0]) begin
        vld[0]   <= bus.in_wreg;
        wd[0]    <= bus.in_wd;
        wdata[0] <= bus.in_wdata;
        rdy[0]   <= ~bus.in_late;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (!bus.stall[i]) begin
          if (bus.stall[i-1]) begin
            vld[i]   <= 1'b0;
            rdy[i]   <= 1'b1;
            wd[i]    <= '0;
            wdata[i] <= '0;
          end else begin
            vld[i] <= vld[i-1];
            wd[i]  <= wd[i-1];
            // Pending load result is filled in as it crosses into the capture stage.
            if (i == LATE_STG && vld[i-1] && !rdy[i-1]) begin
              wdata[i] <= bus.late_wdata;
              rdy[i]   <= 1'b1;
            end else begin
              wdata[i] <= wdata[i-1];
              rdy[i]   <= rdy[i-1];
            end
          end
        end
      end
    end
  end

  logic [ADDR_W-1:0] rd_a [NRD];
  for (genvar p = 0; p < NRD; p++) begin : g_rd_addr
    assign rd_a[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
  end

  logic [NRD-1:0]        fwd_hit;
  logic [NRD-1:0]        fwd_stall;
  logic [NRD*DATA_W-1:0] fwd_data;

  // Scan oldest to youngest so the youngest matching stage is the last writer.
  always_comb begin
    fwd_hit   = '0;
    fwd_stall = '0;
    fwd_data  = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (vld[s] && (rd_a[p] != '0) && (wd[s] == rd_a[p])) begin
          fwd_hit[p]                    = 1'b1;
          fwd_stall[p]                  = ~rdy[s];
          fwd_data[p*DATA_W +: DATA_W]  = wdata[s];
        end
      end
    end
  end

  assign bus.rd_hit   = fwd_hit;
  assign bus.rd_stall = fwd_stall;
  assign bus.rd_data  = fwd_data;
  assign bus.wb_wreg  = vld[DEPTH-1];
  assign bus.wb_wd    = wd[DEPTH-1];
  assign bus.wb_wdata = wdata[DEPTH-1];
  assign bus.busy     = |vld;

endmodule

// File: tb/tb_result_pipe.sv
// Self-checking bench for result_pipe: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a stage model.
module tb_result_pipe;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 3;
  localparam int NRD      = 2;
  localparam int LATE_STG = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD)) bus ();

  result_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD), .LATE_STG(LATE_STG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit                v;
    logic [ADDR_W-1:0] wd;
    logic [DATA_W-1:0] d;
    bit                r;
  } ent_t;

  ent_t m [DEPTH];
  ent_t empty_e = '{v: 1'b0, wd: '0, d: '0, r: 1'b1};

  // Stage model: recompute every stage from the previous snapshot, then compare mid-cycle.
  initial begin
    ent_t nx [DEPTH];
    logic [NRD-1:0]        e_hit, e_st;
    logic [NRD*DATA_W-1:0] e_d;
    logic [ADDR_W-1:0]     a;
    bit                    mono;
    for (int i = 0; i < DEPTH; i++) m[i] = empty_e;
    forever begin
      @(posedge clk);
      mono = 1'b1;
      for (int i = 1; i < DEPTH; i++) if (bus.stall[i] && !bus.stall[i-1]) mono = 1'b0;
      chk("stall_monotonic", 64'(mono), 64'd1);
      for (int i = 0; i < DEPTH; i++) begin
        if (rst || bus.flush)       nx[i] = empty_e;
        else if (bus.stall[i])      nx[i] = m[i];
        else if (i == 0)            nx[i] = '{v: bus.in_wreg, wd: bus.in_wd, d: bus.in_wdata, r: !bus.in_late};
        else if (bus.stall[i-1])    nx[i] = empty_e;
        else begin
          nx[i] = m[i-1];
          if (i == LATE_STG && nx[i].v && !nx[i].r) begin
            nx[i].d = bus.late_wdata;
            nx[i].r = 1'b1;
          end
        end
      end
      m = nx;
      @(negedge clk);
      e_hit = '0; e_st = '0; e_d = '0;
      for (int p = 0; p < NRD; p++) begin
        a = bus.rd_addr[p*ADDR_W +: ADDR_W];
        for (int s = 0; s < DEPTH; s++) begin
          if (a != 0 && m[s].v && m[s].wd == a) begin
            e_hit[p] = 1'b1;
            e_st[p]  = !m[s].r;
            e_d[p*DATA_W +: DATA_W] = m[s].d;
            break;
          end
        end
      end
      chk("m_rd_hit",   64'(bus.rd_hit),   64'(e_hit));
      chk("m_rd_stall", 64'(bus.rd_stall), 64'(e_st));
      chk("m_rd_data",  64'(bus.rd_data),  64'(e_d));
      chk("m_wb_wreg",  64'(bus.wb_wreg),  64'(m[DEPTH-1].v));
      chk("m_wb_wd",    64'(bus.wb_wd),    64'(m[DEPTH-1].wd));
      chk("m_wb_wdata", 64'(bus.wb_wdata), 64'(m[DEPTH-1].d));
      chk("m_busy",     64'(bus.busy),     64'(m[0].v | m[1].v | m[2].v));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit wreg, int wd, logic [DATA_W-1:0] d, bit late);
    bus.in_wreg  = wreg;
    bus.in_wd    = ADDR_W'(wd);
    bus.in_wdata = d;
    bus.in_late  = late;
  endtask

  task automatic set_rd(int a0, int a1);
    bus.rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic idle(int n);
    set_in(0, 0, '0, 0);
    bus.stall = '0;
    bus.flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, '0, 0);
    bus.late_wdata = '0;
    bus.stall = '0;
    bus.flush = 1'b0;
    set_rd(0, 0);
    step();
    step();
    chk("reset_busy",  64'(bus.busy),     64'd0);
    chk("reset_wreg",  64'(bus.wb_wreg),  64'd0);
    chk("reset_wd",    64'(bus.wb_wd),    64'd0);
    chk("reset_wdata", 64'(bus.wb_wdata), 64'd0);
    rst = 1'b0;
    step();

    // Single write to r3 flows through and retires.
    set_rd(3, 0);
    set_in(1, 3, 32'h1234, 0);
    step();
    set_in(0, 0, '0, 0);
    chk("t1_hit_s0",  64'(bus.rd_hit[0]), 64'd1);
    chk("t1_data_s0", 64'(bus.rd_data[31:0]), 64'h1234);
    chk("t1_wb_early", 64'(bus.wb_wreg), 64'd0);
    step();
    chk("t1_hit_s1",  64'(bus.rd_hit[0]), 64'd1);
    step();
    chk("t1_wb", 64'({bus.wb_wreg, bus.wb_wd, bus.wb_wdata}), {1'b1, 5'd3, 32'h1234});
    chk("t1_hit_s2",  64'(bus.rd_data[31:0]), 64'h1234);
    step();
    chk("t1_idle", 64'({bus.busy, bus.rd_hit[0]}), 64'd0);

    // Back-to-back writes to r5: youngest wins.
    set_rd(5, 0);
    set_in(1, 5, 32'hA, 0);
    step();
    set_in(1, 5, 32'hB, 0);
    step();
    set_in(0, 0, '0, 0);
    chk("t2_young_a", 64'(bus.rd_data[31:0]), 64'hB);
    step();
    chk("t2_young_b", 64'(bus.rd_data[31:0]), 64'hB);
    step();
    chk("t2_young_c", 64'(bus.rd_data[31:0]), 64'hB);
    step();
    chk("t2_retired", 64'(bus.rd_hit[0]), 64'd0);
    idle(2);

    // Late data for r7 captured on the stage1->stage2 move.
    set_rd(7, 0);
    bus.late_wdata = 32'hDEAD;
    set_in(1, 7, 32'h0, 1);
    step();
    set_in(0, 0, '0, 0);
    chk("t3_stall_s0", 64'({bus.rd_hit[0], bus.rd_stall[0]}), 64'b11);
    step();
    chk("t3_stall_s1", 64'({bus.rd_hit[0], bus.rd_stall[0]}), 64'b11);
    bus.late_wdata = 32'hCAFE;
    step();
    bus.late_wdata = 32'hBEEF;
    chk("t3_ready",   64'({bus.rd_stall[0], bus.rd_data[31:0]}), {1'b0, 32'hCAFE});
    chk("t3_wb_data", 64'(bus.wb_wdata), 64'hCAFE);
    idle(3);

    // Stall stage 0 one cycle: bubble into stage 1, r4 retires a cycle late.
    set_rd(4, 0);
    set_in(1, 4, 32'h44, 0);
    step();
    set_in(0, 0, '0, 0);
    bus.stall = 3'b001;
    step();
    bus.stall = 3'b000;
    chk("t4_held", 64'({bus.rd_hit[0], bus.rd_data[31:0]}), {1'b1, 32'h44});
    step();
    chk("t4_wb_not_yet", 64'(bus.wb_wreg), 64'd0);
    step();
    chk("t4_wb", 64'({bus.wb_wreg, bus.wb_wd, bus.wb_wdata}), {1'b1, 5'd4, 32'h44});
    idle(2);

    // Flush wins over a full stall.
    set_rd(1, 2);
    set_in(1, 1, 32'h11, 0);
    step();
    set_in(1, 2, 32'h22, 0);
    step();
    set_in(1, 6, 32'h66, 0);
    chk("t5_pre_hits", 64'(bus.rd_hit), 64'b11);
    bus.flush = 1'b1;
    bus.stall = 3'b111;
    step();
    bus.flush = 1'b0;
    bus.stall = 3'b000;
    set_in(0, 0, '0, 0);
    chk("t5_flushed", 64'({bus.busy, bus.rd_hit, bus.wb_wreg}), 64'd0);
    idle(2);

    // r0 never forwards; reset mid-flight discards everything.
    set_rd(0, 9);
    set_in(1, 0, 32'hFFFF, 0);
    step();
    chk("t6_r0_nohit", 64'(bus.rd_hit[0]), 64'd0);
    set_in(1, 9, 32'h99, 0);
    step();
    set_in(0, 0, '0, 0);
    chk("t6_r9_hit", 64'(bus.rd_hit[1]), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_all", 64'({bus.busy, bus.rd_hit, bus.wb_wreg, bus.wb_wd, bus.wb_wdata}), 64'd0);
    step();
    chk("t6_no_wb_a", 64'(bus.wb_wreg), 64'd0);
    step();
    chk("t6_no_wb_b", 64'(bus.wb_wreg), 64'd0);

    // Randomized traffic; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      int r, k;
      rst       = ($urandom_range(0, 149) == 0);
      bus.flush = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom, $urandom_range(0, 2) == 0);
      bus.late_wdata = $urandom;
      r = $urandom_range(0, 9);
      k = (r < 6) ? 0 : r - 6;
      bus.stall = DEPTH'((1 << k) - 1);
      set_rd($urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
